// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the L1 cache control FSM.
//   state_t     : controller state encoding
//   DSEL_*      : data_sel mux codes (CPU write-merge vs. pmem line)
//   ASEL_*      : addr_sel mux codes (CPU address vs. victim {tag,index})
//   hit_way     : resolves the per-way hit vector to a single way
//   way_mask    : one-hot per-way strobe for a given way
package cache_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2
   } state_t;

   localparam logic DSEL_CPU    = 1'b0;
   localparam logic DSEL_PMEM   = 1'b1;
   localparam logic ASEL_CPU    = 1'b0;
   localparam logic ASEL_VICTIM = 1'b1;

   // Both ways hitting should never happen with consistent tags; way 0 wins.
   function automatic logic hit_way(input logic [1:0] hit);
      return hit[0] ? 1'b0 : 1'b1;
   endfunction

   function automatic logic [1:0] way_mask(input logic way);
      return way ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative, write-back, write-allocate L1.
// Sequences the valid/dirty/tag/LRU/data arrays held in the datapath and
// handles the CPU and physical-memory handshakes. Only storage: state.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_read, mem_write      CPU requests, held until mem_resp
//   hit[1:0]                 per-way tag match & valid of the indexed set
//   dirty[1:0], lru          dirty bits / LRU (victim) bit of the indexed set
//   pmem_resp                memory completion for the outstanding line transfer
//   mem_resp                 one-cycle CPU completion
//   pmem_read, pmem_write    line fill / writeback requests
//   valid_load, tag_load,
//   data_load, dirty_load    per-way array write enables
//   lru_load, dirty_in, lru_in  LRU enable and dirty/LRU write values
//   data_sel, addr_sel, way_sel datapath mux selects
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | serve hits in one cycle; on a miss pick next transfer
// ST_WRITEBACK | write dirty victim line (way = lru) back to memory
// ST_ALLOCATE  | fill victim way from memory, then return to IDLE to re-hit
module cache_control
   import cache_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_read,
   input  logic       mem_write,
   input  logic [1:0] hit,
   input  logic [1:0] dirty,
   input  logic       lru,
   input  logic       pmem_resp,
   output logic       mem_resp,
   output logic       pmem_read,
   output logic       pmem_write,
   output logic [1:0] valid_load,
   output logic [1:0] tag_load,
   output logic [1:0] data_load,
   output logic [1:0] dirty_load,
   output logic       lru_load,
   output logic       dirty_in,
   output logic       lru_in,
   output logic       data_sel,
   output logic       addr_sel,
   output logic       way_sel
);

   state_t state;
   state_t state_nxt;

   logic req;
   logic is_hit;
   logic hw;

   assign req    = mem_read | mem_write;
   assign is_hit = |hit;
   assign hw     = hit_way(hit);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req && !is_hit) state_nxt = dirty[lru] ? ST_WRITEBACK : ST_ALLOCATE;
         end
         ST_WRITEBACK: begin
            if (pmem_resp) state_nxt = ST_ALLOCATE;
         end
         ST_ALLOCATE: begin
            if (pmem_resp) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      valid_load = 2'b00;
      tag_load   = 2'b00;
      data_load  = 2'b00;
      dirty_load = 2'b00;
      lru_load   = 1'b0;
      dirty_in   = 1'b0;
      lru_in     = 1'b0;
      data_sel   = DSEL_CPU;
      addr_sel   = ASEL_CPU;
      way_sel    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req && is_hit) begin
               mem_resp = 1'b1;
               way_sel  = hw;
               lru_load = 1'b1;
               lru_in   = ~hw;
               // read+write together is a write
               if (mem_write) begin
                  data_load  = way_mask(hw);
                  dirty_load = way_mask(hw);
                  dirty_in   = 1'b1;
                  data_sel   = DSEL_CPU;
               end
            end
         end
         ST_WRITEBACK: begin
            pmem_write = 1'b1;
            addr_sel   = ASEL_VICTIM;
            way_sel    = lru;
         end
         ST_ALLOCATE: begin
            pmem_read = 1'b1;
            addr_sel  = ASEL_CPU;
            if (pmem_resp) begin
               data_load  = way_mask(lru);
               tag_load   = way_mask(lru);
               valid_load = way_mask(lru);
               dirty_load = way_mask(lru);
               dirty_in   = 1'b0;
               data_sel   = DSEL_PMEM;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: directed scenarios followed by random
// transactions, each cycle compared against a transaction-level model.
module tb_cache_control;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_read, mem_write;
   logic [1:0] hit, dirty;
   logic       lru, pmem_resp;
   logic       mem_resp, pmem_read, pmem_write;
   logic [1:0] valid_load, tag_load, data_load, dirty_load;
   logic       lru_load, dirty_in, lru_in, data_sel, addr_sel, way_sel;

   int n_assert = 0;
   int n_fail   = 0;

   localparam int XF_WB   = 1;
   localparam int XF_FILL = 2;

   // Outstanding line transfers for the current miss, in order.
   int xfer_q[$];

   cache_control dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .hit(hit), .dirty(dirty), .lru(lru), .pmem_resp(pmem_resp),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .valid_load(valid_load), .tag_load(tag_load),
      .data_load(data_load), .dirty_load(dirty_load),
      .lru_load(lru_load), .dirty_in(dirty_in), .lru_in(lru_in),
      .data_sel(data_sel), .addr_sel(addr_sel), .way_sel(way_sel)
   );

   always #5 clk = ~clk;

   // Expected output vector, same packing as the observed vector in step().
   function automatic logic [16:0] model_out();
      logic       o_resp, o_prd, o_pwr, o_lld, o_din, o_lin, o_dsel, o_asel, o_way;
      logic [1:0] o_vld, o_tld, o_dld, o_dyld, vm;
      int         w;
      {o_resp, o_prd, o_pwr, o_lld, o_din, o_lin, o_dsel, o_asel, o_way} = '0;
      {o_vld, o_tld, o_dld, o_dyld} = '0;
      vm = (lru == 1'b1) ? 2'b10 : 2'b01;
      if (xfer_q.size() == 0) begin
         if ((mem_read || mem_write) && hit != 2'b00) begin
            w      = (hit[0] == 1'b1) ? 0 : 1;
            o_resp = 1'b1;
            o_way  = (w == 1);
            o_lld  = 1'b1;
            o_lin  = (w == 0);
            if (mem_write) begin
               o_dld  = 2'(1 << w);
               o_dyld = 2'(1 << w);
               o_din  = 1'b1;
            end
         end
      end else if (xfer_q[0] == XF_WB) begin
         o_pwr  = 1'b1;
         o_asel = 1'b1;
         o_way  = lru;
      end else begin
         o_prd = 1'b1;
         if (pmem_resp) begin
            o_dld  = vm;
            o_tld  = vm;
            o_vld  = vm;
            o_dyld = vm;
            o_dsel = 1'b1;
         end
      end
      return {o_resp, o_prd, o_pwr, o_vld, o_tld, o_dld, o_dyld,
              o_lld, o_din, o_lin, o_dsel, o_asel, o_way};
   endfunction

   function automatic void model_update();
      if (rst) begin
         xfer_q.delete();
      end else if (xfer_q.size() == 0) begin
         if ((mem_read || mem_write) && hit == 2'b00) begin
            if (dirty[lru]) xfer_q.push_back(XF_WB);
            xfer_q.push_back(XF_FILL);
         end
      end else if (pmem_resp) begin
         void'(xfer_q.pop_front());
      end
   endfunction

   task automatic step(input string tag);
      logic [16:0] exp_v, obs_v;
      @(negedge clk);
      exp_v = model_out();
      obs_v = {mem_resp, pmem_read, pmem_write, valid_load, tag_load, data_load,
               dirty_load, lru_load, dirty_in, lru_in, data_sel, addr_sel, way_sel};
      n_assert++;
      assert (obs_v === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs_v, exp_v);
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   // op: 0 read, 1 write, 2 read+write
   task automatic do_txn(input string tag, input int op, input logic [1:0] h,
                         input logic [1:0] d, input logic l,
                         input int wb_lat, input int fill_lat);
      mem_read  = (op != 1);
      mem_write = (op != 0);
      hit = h; dirty = d; lru = l; pmem_resp = 1'b0;
      step({tag, "_req"});
      if (h == 2'b00) begin
         if (d[l]) begin
            for (int i = 1; i < wb_lat; i++) step({tag, "_wb"});
            pmem_resp = 1'b1;
            step({tag, "_wb_resp"});
            pmem_resp = 1'b0;
         end
         for (int i = 1; i < fill_lat; i++) step({tag, "_fill"});
         pmem_resp = 1'b1;
         step({tag, "_fill_resp"});
         pmem_resp = 1'b0;
         hit = l ? 2'b10 : 2'b01;
         dirty[l] = 1'b0;
         step({tag, "_rehit"});
      end
      mem_read = 1'b0; mem_write = 1'b0;
      step({tag, "_done"});
   endtask

   task automatic reset_mid_fill(input string tag, input logic l, input int pre);
      mem_read = 1'b1; mem_write = 1'b0;
      hit = 2'b00; dirty = 2'b00; lru = l; pmem_resp = 1'b0;
      step({tag, "_req"});
      for (int i = 0; i < pre; i++) step({tag, "_fill"});
      rst = 1'b1;
      step({tag, "_rst"});
      rst = 1'b0;
      mem_read = 1'b0;
      pmem_resp = 1'b1;
      step({tag, "_late_resp"});
      pmem_resp = 1'b0;
      step({tag, "_idle"});
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      hit = 2'b00; dirty = 2'b00; lru = 1'b0; pmem_resp = 1'b0;
      @(posedge clk); #1;
      xfer_q.delete();
      step("reset");
      rst = 1'b0;
      step("idle_norq");

      do_txn("rd_hit_w1", 0, 2'b10, 2'b00, 1'b0, 1, 1);
      do_txn("wr_hit_w0", 1, 2'b01, 2'b00, 1'b1, 1, 1);
      do_txn("clean_miss", 0, 2'b00, 2'b00, 1'b1, 1, 3);
      do_txn("dirty_miss", 1, 2'b00, 2'b01, 1'b0, 2, 3);
      do_txn("dirty_miss_w1", 0, 2'b00, 2'b10, 1'b1, 1, 1);
      reset_mid_fill("rst_alloc", 1'b1, 2);
      do_txn("rw_hit_both", 2, 2'b11, 2'b00, 1'b1, 1, 1);

      pmem_resp = 1'b1;
      step("idle_spurious_resp");
      pmem_resp = 1'b0;
      step("idle_after_spurious");

      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 7) == 0) begin
            reset_mid_fill("rnd_rst", 1'($urandom_range(0, 1)), $urandom_range(0, 3));
         end else begin
            do_txn("rnd", $urandom_range(0, 2), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 4), $urandom_range(1, 4));
         end
         if ($urandom_range(0, 3) == 0) begin
            pmem_resp = 1'($urandom_range(0, 1));
            step("rnd_idle");
            pmem_resp = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_control.md
# cache_control

Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache. It sits between the CPU-side request port and the physical-memory port and sequences the per-set valid, dirty, tag, LRU and data arrays held in the cache datapath. It produces every array load strobe, every datapath mux select and the CPU and memory handshakes. It holds no storage other than its state register.

## Interface
- No parameters. Way count is fixed at 2; index and tag widths live only in the datapath.

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- hit  in  2  per-way tag-match AND valid for the indexed set (combinational from datapath)
- dirty  in  2  dirty bits of the indexed set
- lru  in  1  LRU bit of the indexed set (victim way)
- pmem_resp  in  1  memory completion pulse for the outstanding line transfer
- mem_resp  out  1  one-cycle CPU completion
- pmem_read  out  1  line fill request; held until pmem_resp
- pmem_write  out  1  line writeback request; held until pmem_resp
- valid_load, tag_load, data_load, dirty_load  out  2  per-way array write enables
- lru_load  out  1  LRU array write enable
- dirty_in  out  1  value written to the dirty array
- lru_in  out  1  value written to the LRU array
- data_sel  out  1  0 = CPU write-merge, 1 = pmem line
- addr_sel  out  1  0 = CPU address, 1 = victim {tag,index}
- way_sel  out  1  way driven to CPU read data / writeback data

## Operation
- States: IDLE, WRITEBACK, ALLOCATE. Outputs are combinational from state plus inputs. Any output not listed for a state is 0.
- IDLE, no request: all outputs 0.
- IDLE, hit (hit != 0):
  - way w = 0 if hit[0], else 1; both bits set resolves to way 0.
  - Assert mem_resp and way_sel = w.
  - lru_load = 1, lru_in = ~w.
  - If mem_write: data_load[w] = 1, dirty_load[w] = 1, dirty_in = 1, data_sel = 0.
  - Stay in IDLE.
- IDLE, miss: v = lru. Next state is WRITEBACK if dirty[v], else ALLOCATE. No strobes this cycle.
- WRITEBACK:
  - pmem_write = 1, addr_sel = 1, way_sel = lru.
  - On pmem_resp go to ALLOCATE; otherwise hold.
- ALLOCATE:
  - pmem_read = 1, addr_sel = 0.
  - On pmem_resp, for way v = lru: data_load[v], tag_load[v] and valid_load[v] = 1; dirty_load[v] = 1 with dirty_in = 0; data_sel = 1. Then go to IDLE.
  - The following IDLE cycle re-evaluates and hits.
- mem_read and mem_write together: treat as a write.
- lru is read in every cycle because the arrays read asynchronously. The set index must not change while a miss is in flight; the CPU holds its address until mem_resp.

## Timing
- Reset: state goes to IDLE at the reset edge. With no request, every output is 0 after reset.
- Reset mid-WRITEBACK or mid-ALLOCATE aborts the transfer. pmem strobes are low in the first cycle after the edge, and no array is loaded.
- Hit latency: mem_resp in the same cycle the request is sampled in IDLE.
- Clean miss: 1 (IDLE) + N (ALLOCATE, until pmem_resp) + 1 (IDLE hit) cycles.
- Dirty miss: 1 + M (WRITEBACK) + N (ALLOCATE) + 1 cycles.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- pmem_read and pmem_write are never both high.
- mem_resp is high for exactly one cycle per request.

## Structure
- cache_ctrl_pkg holds:
  - state enum (IDLE, WRITEBACK, ALLOCATE)
  - data_sel constants (DSEL_CPU = 0, DSEL_PMEM = 1)
  - addr_sel constants (ASEL_CPU = 0, ASEL_VICTIM = 1)
- No sub-module: one state register, a next-state block, and one combinational output block with all defaults assigned first.

## Test plan
- Read hit way 1: hit=2'b10, mem_read=1 -> mem_resp=1 in the same cycle, way_sel=1, lru_load=1, lru_in=0, all pmem strobes 0.
- Write hit way 0: hit=2'b01, mem_write=1 -> data_load=2'b01, dirty_load=2'b01, dirty_in=1, data_sel=0, mem_resp=1, lru_in=1.
- Clean miss: hit=0, lru=1, dirty=2'b00, pmem_resp after 3 cycles:
  - -> ALLOCATE with pmem_read high for 3 cycles.
  - On resp: tag_load, valid_load and data_load = 2'b10, dirty_in=0, data_sel=1.
  - Then, with hit=2'b10, mem_resp arrives one cycle later.
- Dirty miss: lru=0, dirty=2'b01:
  - -> WRITEBACK with pmem_write=1, addr_sel=1, way_sel=0 until pmem_resp.
  - -> ALLOCATE with pmem_read=1 until pmem_resp.
  - -> IDLE hit.
  - pmem_read and pmem_write are never overlapped.
- Reset in ALLOCATE: rst=1 for 1 cycle mid-fill -> next cycle state IDLE, pmem_read=0, no load strobes; a late pmem_resp is ignored.
- Simultaneous read+write hit with hit=2'b11 -> treated as a write to way 0 with a single mem_resp.
